// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif
`ifndef MEM_WIDTH
`define MEM_WIDTH 32
`endif

package mem_arb_pkg;

  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int IDX_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = IDX_W(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      gnt_idx,
  output logic               any
);

  // Scan upward from ptr; the first hit wins.
  always_comb begin : p_pick
    int k;
    k       = 0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[k]) begin
        any     = 1'b1;
        gnt_idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port among NUM_REQ
// requesters. Requests are registered before issue; a hung slave is aborted
// after TIMEOUT cycles (0 disables) and reported with req_err_o.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = `MEM_ADDR_WIDTH,
  parameter int WIDTH      = `MEM_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_wr_rd_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [WIDTH-1:0]              req_rdata_o,
  output logic                          req_err_o,
  output logic                          mem_valid_o,
  output logic                          mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [WIDTH-1:0]              mem_wdata_o,
  input  logic                          mem_ready_i,
  input  logic [WIDTH-1:0]              mem_rdata_i,
  output logic                          busy_o
);

  localparam int IW = IDX_W(NUM_REQ);

  arb_state_e              r_state;
  logic [IW-1:0]           r_ptr;
  logic [IW-1:0]           r_idx;
  logic                    r_wr_rd;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [WIDTH-1:0]        r_wdata;
  logic [31:0]             r_cnt;
  logic [NUM_REQ-1:0]      r_ready;
  logic [WIDTH-1:0]        r_rdata;
  logic                    r_err;
  logic                    r_mem_valid;
  logic                    r_busy;

  logic [IW-1:0]           w_gnt_idx;
  logic                    w_any;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [WIDTH-1:0]        w_sel_wdata;
  logic                    w_timeout;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req     (req_valid_i),
    .ptr     (r_ptr),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign w_sel_addr  = req_addr_i[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_wdata = req_wdata_i[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == 32'(TIMEOUT - 1));

  assign req_ready_o = r_ready;
  assign req_rdata_o = r_rdata;
  assign req_err_o   = r_err;
  assign mem_valid_o = r_mem_valid;
  assign mem_wr_rd_o = r_wr_rd;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign busy_o      = r_busy;

  // Arbitration FSM: grant in IDLE, hold the issue registers through ISSUE,
  // one-cycle response pulse in RESP. Every output is a register here.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_wr_rd     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_ready     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_mem_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_ready <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_idx       <= w_gnt_idx;
            r_wr_rd     <= req_wr_rd_i[w_gnt_idx];
            r_addr      <= w_sel_addr;
            r_wdata     <= w_sel_wdata;
            r_ptr       <= (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            r_cnt       <= '0;
            r_mem_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Ready takes priority over a timeout landing in the same cycle.
          if (mem_ready_i) begin
            r_rdata     <= r_wr_rd ? '0 : mem_rdata_i;
            r_err       <= 1'b0;
            r_ready     <= NUM_REQ'(1) << r_idx;
            r_mem_valid <= 1'b0;
            r_state     <= RESP;
          end else if (w_timeout) begin
            r_rdata     <= '0;
            r_err       <= 1'b1;
            r_ready     <= NUM_REQ'(1) << r_idx;
            r_mem_valid <= 1'b0;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter: a transaction-level model predicts
// grants and responses; a separate monitor pops and compares responses.
module tb_mem_rr_arbiter;

  localparam int NR = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_wr = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]   req_ready_o;
  logic [DW-1:0]   req_rdata_o;
  logic            req_err_o;
  logic            mem_valid_o;
  logic            mem_wr_rd_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic            mem_ready = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;
  logic            busy_o;

  mem_rr_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .req_valid_i (req_valid),
    .req_wr_rd_i (req_wr),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_ready_o (req_ready_o),
    .req_rdata_o (req_rdata_o),
    .req_err_o   (req_err_o),
    .mem_valid_o (mem_valid_o),
    .mem_wr_rd_o (mem_wr_rd_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          idx;
    logic [DW-1:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q[$];
  int   g_log[$];
  int   g_cyc[$];
  int   r_cyc[$];
  logic r_err[$];
  logic [DW-1:0] r_rd[$];

  // slave behaviour knobs
  bit            slv_rand = 1'b0;
  int            slv_delay_fix = 0;
  logic [DW-1:0] slv_rdata_fix = '0;
  bit            hold_mode = 1'b0;

  typedef enum int {M_IDLE, M_ISSUE, M_RESP} mst_e;
  mst_e          st = M_IDLE;
  int            m_ptr = 0;
  int            m_cur = 0;
  int            m_wait = 0;
  int            m_delay = 0;
  bit            m_fin = 1'b0;
  logic [NR-1:0] v_edge = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int i = 0; i < NR; i++)
      if (v[(p + i) % NR]) return (p + i) % NR;
    return 0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    v_edge = req_valid;
  end

  // Reference model + slave: decides the winner from the requests present at
  // each sampling edge and predicts every response with its due cycle.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      st = M_IDLE; m_ptr = 0; m_fin = 1'b0; mem_ready = 1'b0;
      q.delete();
    end else begin
      case (st)
        M_IDLE: if (v_edge != '0) begin
          m_cur  = pick(v_edge, m_ptr);
          m_ptr  = (m_cur + 1) % NR;
          m_wait = 0;
          m_fin  = 1'b0;
          if (slv_rand) m_delay = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, 9));
          else          m_delay = slv_delay_fix;
          g_log.push_back(m_cur);
          g_cyc.push_back(cyc);
          st = M_ISSUE;
        end
        M_ISSUE: if (m_fin) st = M_RESP;
        M_RESP:  st = M_IDLE;
        default: st = M_IDLE;
      endcase
      chk("mem_valid", 64'(mem_valid_o), 64'(st == M_ISSUE));
      chk("busy", 64'(busy_o), 64'(st != M_IDLE));
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (st == M_ISSUE) begin
        exp_t e;
        chk("mem_addr", 64'(mem_addr_o), 64'(req_addr[m_cur*AW +: AW]));
        chk("mem_wr", 64'(mem_wr_rd_o), 64'(req_wr[m_cur]));
        chk("mem_wdata", 64'(mem_wdata_o), 64'(req_wdata[m_cur*DW +: DW]));
        e.idx = m_cur;
        e.due = cyc + 1;
        if (m_wait == m_delay) begin
          mem_ready = 1'b1;
          mem_rdata = slv_rand ? DW'($urandom) : slv_rdata_fix;
          e.rdata   = req_wr[m_cur] ? '0 : mem_rdata;
          e.err     = 1'b0;
          q.push_back(e);
          m_fin = 1'b1;
        end else if (m_wait == TO - 1) begin
          e.rdata = '0;
          e.err   = 1'b1;
          q.push_back(e);
          m_fin = 1'b1;
        end
        m_wait++;
      end
    end
  end

  // Monitor: every cycle either the front expectation is due or no pulse.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("resp_ready", 64'(req_ready_o), 64'(NR'(1) << e.idx));
        chk("resp_rdata", 64'(req_rdata_o), 64'(e.rdata));
        chk("resp_err", 64'(req_err_o), 64'(e.err));
        r_cyc.push_back(cyc);
        r_err.push_back(req_err_o);
        r_rd.push_back(req_rdata_o);
        if (!hold_mode) req_valid[e.idx] = 1'b0;
      end else begin
        chk("no_resp", 64'(req_ready_o), 64'(0));
      end
    end
  end

  task automatic issue(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr[k] = wr;
    req_addr[k*AW +: AW] = a;
    req_wdata[k*DW +: DW] = d;
    req_valid[k] = 1'b1;
  endtask

  task automatic clear_logs();
    g_log.delete(); g_cyc.delete(); r_cyc.delete(); r_err.delete(); r_rd.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    req_valid = '0;
    hold_mode = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((req_valid != '0 || st != M_IDLE || q.size() != 0) && n < 2000);
    chk("drain_bound", 64'(n < 2000), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(req_ready_o), 64'(0));
    chk("rst_rdata", 64'(req_rdata_o), 64'(0));
    chk("rst_err", 64'(req_err_o), 64'(0));
    chk("rst_mvalid", 64'(mem_valid_o), 64'(0));
    chk("rst_mwr", 64'(mem_wr_rd_o), 64'(0));
    chk("rst_maddr", 64'(mem_addr_o), 64'(0));
    chk("rst_mwdata", 64'(mem_wdata_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    #2 rst_n = 1'b1;

    // single read: requester 2, slave ready on first ISSUE cycle
    slv_rand = 1'b0; slv_delay_fix = 0; slv_rdata_fix = 32'hA5;
    @(negedge clk); #1;
    issue(2, 1'b0, 16'h0010, 32'h0);
    @(negedge clk); @(negedge clk); #1;
    chk("single_ready", 64'(req_ready_o), 64'(4'b0100));
    chk("single_rdata", 64'(req_rdata_o), 64'(32'hA5));
    chk("single_err", 64'(req_err_o), 64'(0));
    wait_idle();

    // round robin: all four hold writes continuously
    do_reset();
    slv_delay_fix = 0;
    hold_mode = 1'b1;
    @(negedge clk); #1;
    for (int k = 0; k < NR; k++) issue(k, 1'b1, AW'(16'h100 + k), DW'($urandom));
    begin
      int n;
      n = 0;
      while (g_log.size() < 5 && n < 200) begin @(negedge clk); #1; n++; end
    end
    hold_mode = 1'b0;
    chk("rr_count", 64'(g_log.size() >= 5), 64'(1));
    if (g_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", 64'(g_log[i]), 64'(i % NR));
      for (int i = 1; i < 5; i++) chk("rr_spacing", 64'(g_cyc[i] - g_cyc[i-1]), 64'(3));
    end
    wait_idle();

    // pointer wrap: ptr=3 after serving requester 2, then 3 and 0 compete
    do_reset();
    @(negedge clk); #1;
    issue(2, 1'b0, 16'h0200, 32'h0);
    wait_idle();
    clear_logs();
    issue(3, 1'b0, 16'h0300, 32'h0);
    issue(0, 1'b1, 16'h0000, 32'hDEAD_BEEF);
    wait_idle();
    chk("wrap_n", 64'(g_log.size()), 64'(2));
    if (g_log.size() == 2) begin
      chk("wrap_first", 64'(g_log[0]), 64'(3));
      chk("wrap_second", 64'(g_log[1]), 64'(0));
    end

    // slave stall of 5 cycles: payload checked every ISSUE cycle by the model
    clear_logs();
    slv_delay_fix = 5; slv_rdata_fix = 32'h1234_5678;
    issue(1, 1'b0, 16'h0ABC, 32'h0);
    wait_idle();
    if (g_cyc.size() == 1 && r_cyc.size() == 1)
      chk("stall_latency", 64'(r_cyc[0] - g_cyc[0]), 64'(6));
    else
      chk("stall_txn", 64'(r_cyc.size()), 64'(1));

    // timeout: slave never ready
    clear_logs();
    slv_delay_fix = 100;
    issue(0, 1'b0, 16'h0044, 32'h0);
    wait_idle();
    if (g_cyc.size() == 1 && r_cyc.size() == 1) begin
      chk("to_edge", 64'(r_cyc[0] - g_cyc[0]), 64'(TO));
      chk("to_err", 64'(r_err[0]), 64'(1));
      chk("to_rdata", 64'(r_rd[0]), 64'(0));
    end else chk("to_txn", 64'(r_cyc.size()), 64'(1));

    // ready coinciding with the timeout cycle wins
    clear_logs();
    slv_delay_fix = TO - 1; slv_rdata_fix = 32'h0BAD_F00D;
    issue(3, 1'b0, 16'h0055, 32'h0);
    wait_idle();
    if (r_cyc.size() == 1) begin
      chk("coin_err", 64'(r_err[0]), 64'(0));
      chk("coin_rdata", 64'(r_rd[0]), 64'(32'h0BAD_F00D));
    end else chk("coin_txn", 64'(r_cyc.size()), 64'(1));

    // randomized traffic
    slv_rand = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); #1;
      for (int k = 0; k < NR; k++)
        if (!req_valid[k] && $urandom_range(0, 5) == 0)
          issue(k, 1'($urandom), AW'($urandom), DW'($urandom));
    end
    wait_idle();

    // reset mid-ISSUE
    slv_rand = 1'b0; slv_delay_fix = 100;
    issue(1, 1'b0, 16'h0777, 32'h0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_mvalid", 64'(mem_valid_o), 64'(0));
    chk("mid_rst_busy", 64'(busy_o), 64'(0));
    chk("mid_rst_ready", 64'(req_ready_o), 64'(0));
    req_valid = '0;
    clear_logs();
    @(negedge clk); #1;
    chk("mid_rst_ready2", 64'(req_ready_o), 64'(0));
    slv_delay_fix = 0;
    issue(3, 1'b0, 16'h0333, 32'h0);
    issue(0, 1'b0, 16'h0111, 32'h0);
    @(negedge clk); #2 rst_n = 1'b1;
    wait_idle();
    chk("post_rst_n", 64'(g_log.size()), 64'(2));
    if (g_log.size() == 2) chk("post_rst_first", 64'(g_log[0]), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Round-robin arbiter that shares one memory slave port between `NUM_REQ` requesters. It uses the valid/ready, single-outstanding memory protocol on both sides. It sits between the requesters (BFMs, DMA, CPU stubs) and the memory model, and registers each request before issuing it downstream. A per-transaction timeout protects requesters against a hung slave.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, `` `addr_width ``: address width.
- `WIDTH`, `` `width ``: data width.
- `TIMEOUT`, 64: cycles waiting for `mem_ready_i` before aborting; 0 disables the timeout.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-low.
- `req_valid_i` in NUM_REQ: per-requester request valid, held until the matching `req_ready_o`.
- `req_wr_rd_i` in NUM_REQ: 1 = write, 0 = read.
- `req_addr_i` in NUM_REQ*ADDR_WIDTH: packed addresses; requester k occupies slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata_i` in NUM_REQ*WIDTH: packed write data, sliced the same way.
- `req_ready_o` out NUM_REQ: one-cycle completion pulse, at most one bit set.
- `req_rdata_o` out WIDTH: read data, valid only while a `req_ready_o` bit is high.
- `req_err_o` out 1: timeout flag, qualified by `req_ready_o`.
- `mem_valid_o` out 1: memory request valid.
- `mem_wr_rd_o` out 1: memory write/read select.
- `mem_addr_o` out ADDR_WIDTH: memory address.
- `mem_wdata_o` out WIDTH: memory write data.
- `mem_ready_i` in 1: slave accepts and completes the transfer; `mem_rdata_i` is valid in that cycle.
- `mem_rdata_i` in WIDTH: memory read data.
- `busy_o` out 1: high in ISSUE and RESP.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any `req_valid_i` bit is set, pick the winner: the first set bit searching upward from `ptr` with wrap-around.
  - Register the winner's index, wr_rd, addr and wdata into the issue registers.
  - Set `ptr` = winner+1 mod NUM_REQ, then go to ISSUE.
  - If no request is pending, stay in IDLE and leave `ptr` unchanged.
- ISSUE:
  - `mem_valid_o`=1 and the `mem_*` outputs drive the issue registers, held stable for the whole state.
  - On `mem_valid_o && mem_ready_i`: capture `mem_rdata_i` (reads; writes capture 0), set err=0, go to RESP.
  - When TIMEOUT≠0, the wait counter increments every ISSUE cycle without ready. When it reaches TIMEOUT-1 with no ready:
    - set rdata=0 and err=1;
    - go to RESP;
    - drop `mem_valid_o` next cycle.
  - If ready and the timeout coincide in the same cycle, ready wins and err=0.
- RESP:
  - Assert `req_ready_o[idx]` with `req_rdata_o` and `req_err_o` for exactly one cycle, then go to IDLE.
  - `req_valid_i` is not sampled in RESP. A requester still asserting valid in the following IDLE cycle is treated as a new request.
- Requesters that are not granted see `req_ready_o`=0. Their valid/payload are ignored until their request wins.
- The wait counter clears on entering ISSUE.
- Reset (async, any state):
  - state=IDLE, `ptr`=0;
  - all outputs 0, issue registers and counter 0.
  - An in-flight memory transfer is abandoned with no response to the requester.

## Timing
- The winner is decided from `req_valid_i` sampled at edge N. `mem_valid_o` is high from after edge N.
- If `mem_ready_i` is sampled high at edge M, `req_ready_o` pulses in cycle M→M+1.
- Minimum latency from request to `req_ready_o` is 2 cycles, assuming the slave is ready in its first ISSUE cycle.
- Peak throughput is one transaction per 3 cycles. The IDLE cycle between transactions is mandatory.
- With timeout: `req_ready_o` with err=1 pulses exactly TIMEOUT+1 cycles after the grant edge.
- Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transactions.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `mem_arb_pkg` holds:
  - the `arb_state_e` enum (IDLE, ISSUE, RESP);
  - the `IDX_W = $clog2(NUM_REQ)` helper function;
  - the default TIMEOUT constant.
- Sub-module `rr_picker` (combinational) takes `req` [NUM_REQ] and `ptr` [IDX_W] and produces `gnt_idx` and `any`. It is instantiated once.

## Test plan
- Single read: requester 2 reads addr 0x10, slave ready on first ISSUE cycle with rdata 0xA5 → `req_ready_o`=4'b0100 two cycles after the request edge, `req_rdata_o`=0xA5, err=0.
- Round-robin: all 4 requesters hold writes with slave always ready → grant order 0,1,2,3,0, each 3 cycles apart; `mem_addr_o` matches each requester's addr.
- Pointer wrap: `ptr`=3 with only requesters 3 and 0 requesting → 3 is granted first, then 0.
- Slave stall: slave delays ready 5 cycles → `mem_valid_o` and the `mem_*` payload are held unchanged through the stall; response arrives 1 cycle after ready.
- Timeout: TIMEOUT=8 and slave never ready → err=1, rdata=0, pulse on the 9th cycle after the grant edge, `mem_valid_o` low afterwards; a ready arriving on the same cycle as the timeout gives err=0.
- Reset mid-ISSUE: assert `rst_i`=0 asynchronously → `mem_valid_o`/`busy_o` drop immediately with no `req_ready_o` pulse; after release the first grant goes to requester 0.
